lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit between the ALU result (effective address) and the data memory port.
- Converts a core load/store request (funct3-encoded size/sign) into word-aligned memory transactions with byte enables.
- Splits misaligned accesses that cross a word boundary into two transactions.
- Aligns and sign/zero-extends load data for the write-back mux, and stalls the core while busy.

Parameters:
- MEM_LAT_MAX, 16, cycles the unit waits for m_ack before asserting err and abandoning the access.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core presents an access this cycle
- req_ready  out  1  unit idle and able to accept
- mem_rd  in  1  load request, from main control
- mem_wr  in  1  store request, from main control
- mask  in  3  funct3 encoding:
  - 000 byte, 001 half, 010 word
  - 100 byte unsigned, 101 half unsigned
- addr  in  32  byte address (ALU output)
- wr_data  in  32  store data (rs2)
- stall  out  1  high whenever not idle, or when req_valid is high in idle
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  32  extended load data; 0 for stores and errors
- err  out  1  valid only with rsp_valid: illegal request or timeout
- m_req  out  1  memory transaction request
- m_we  out  1  1 = write
- m_addr  out  32  word-aligned address, bits [1:0] = 00
- m_wdata  out  32  lane-aligned write data
- m_be  out  4  byte enables
- m_ack  in  1  memory completes the transaction this cycle
- m_rdata  in  32  read word, valid with m_ack

Behaviour:
- Reset: all outputs 0 except req_ready = 1; FSM goes to IDLE.
- Reset mid-operation: the access is abandoned, m_req drops on the next edge, and no rsp_valid is issued.
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: capture addr, wr_data, mask and direction. off = addr[1:0]; size = 1, 2 or 4 bytes.
  - Illegal request means mask in {011, 110, 111}, mem_rd == mem_wr, or a store with mask[2] = 1. An illegal request goes straight to RESP with err = 1 and issues no m_req.
  - Otherwise go to ACC0.
- ACC0:
  - m_req = 1, m_addr = {addr[31:2], 00}.
  - m_be = ((1 << size) - 1) << off, truncated to 4 bits.
  - m_wdata = wr_data << 8*off.
  - Outputs are held stable until m_ack.
  - On m_ack: capture m_rdata into lo. If off + size > 4, go to ACC1; else go to RESP.
- ACC1:
  - m_addr = previous word + 4, 32-bit wrap (0xFFFFFFFC + 4 = 0x00000000).
  - m_be = ((1 << size) - 1) >> (4 - off).
  - m_wdata = wr_data >> 8*(4 - off).
  - On m_ack: capture m_rdata into hi, then go to RESP.
- Timeout: a wait counter resets on entry to ACC0 and ACC1. If it reaches MEM_LAT_MAX without m_ack, the unit drops m_req, goes to RESP with err = 1, and produces no further transactions.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then IDLE.
  - Loads: d = {hi, lo} >> 8*off, with hi = 0 if not split. Take the low size bytes; sign-extend if mask[2] = 0, else zero-extend.
  - Stores: rsp_data = 0.
- m_ack is ignored when m_req = 0.
- req_valid is ignored (not captured) outside IDLE.
- Latency with same-cycle ack (accept at cycle T):
  - Aligned: m_req in T+1, rsp_valid in T+2, req_ready = 1 again in T+3.
  - Split: one extra cycle.

Test Plan:
- Word at aligned address: LW addr 0x100, ack same cycle, m_rdata 0xDEADBEEF -> one m_req (m_addr 0x100, m_be 1111); rsp_valid at T+2 with rsp_data 0xDEADBEEF, err 0.
- Byte sign vs zero extension:
  - LB addr 0x103, m_rdata 0x80xxxxxx -> m_be 1000, rsp_data 0xFFFFFF80.
  - LBU at the same address -> rsp_data 0x00000080.
- Split store: SW addr 0x102, wr_data 0x11223344 ->
  - first transaction m_addr 0x100, m_be 1100, m_wdata 0x33440000;
  - second transaction m_addr 0x104, m_be 0011, m_wdata[15:0] 0x1122;
  - rsp_valid with rsp_data 0.
- Split load with wrap: LH addr 0xFFFFFFFF, lo 0xAB000000, hi 0x000000CD -> second m_addr 0x00000000; rsp_data 0xFFFFCDAB.
- Backpressure and timeout:
  - m_ack delayed 3 cycles -> m_addr, m_be and m_wdata stay stable, stall stays 1.
  - m_ack never arrives -> rsp_valid with err = 1 exactly MEM_LAT_MAX cycles after ACC0 entry.
- Illegal request and reset:
  - mask 011 -> no m_req; rsp_valid with err = 1 at T+1.
  - rst asserted during ACC1 -> m_req = 0 and req_ready = 1 on the next edge; no rsp_valid.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit: turns core load/store requests into word-aligned memory
// transactions with byte enables, splitting accesses that cross a word boundary.
module lsu_ctrl #(
  parameter int unsigned MEM_LAT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t             state_q, state_d;
  logic [1:0]         off_q, off_d;
  logic [2:0]         mask_q, mask_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [31:0]        lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               ready_d, rv_d, err_d, req_d, mwe_d;
  logic [31:0]        rdata_d, maddr_d, mwdata_d;
  logic [3:0]         mbe_d;

  logic [1:0]         cur_off;
  logic [2:0]         cur_mask;
  logic [31:0]        cur_wdata;
  logic [2:0]         size;
  logic [7:0]         be_wide;
  logic [63:0]        wd_wide;
  logic               split;
  logic               illegal;

  // Shift the {hi,lo} pair down to the access offset, then extend to 32 bits
  function automatic logic [31:0] extend(input logic [31:0] lo, input logic [31:0] hi,
                                         input logic [1:0] off, input logic [2:0] mk);
    logic [63:0] w;
    logic [31:0] d;
    w = {hi, lo} >> {off, 3'b000};
    d = w[31:0];
    case (mk[1:0])
      2'b00:   extend = {{24{~mk[2] & d[7]}}, d[7:0]};
      2'b01:   extend = {{16{~mk[2] & d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  // In IDLE the lane math works on the incoming request, afterwards on the captured one
  always_comb begin
    cur_off   = (state_q == IDLE) ? addr[1:0] : off_q;
    cur_mask  = (state_q == IDLE) ? mask      : mask_q;
    cur_wdata = (state_q == IDLE) ? wr_data   : wdata_q;
    case (cur_mask[1:0])
      2'b00:   begin size = 3'd1; be_wide = 8'h01; end
      2'b01:   begin size = 3'd2; be_wide = 8'h03; end
      default: begin size = 3'd4; be_wide = 8'h0F; end
    endcase
    be_wide = be_wide << cur_off;
    wd_wide = {32'h0, cur_wdata} << {cur_off, 3'b000};
    split   = ({1'b0, cur_off} + size) > 3'd4;
    illegal = (mask == 3'b011) || (mask == 3'b110) || (mask == 3'b111) ||
              (mem_rd == mem_wr) || (mem_wr && mask[2]);
  end

  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    mask_d   = mask_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    rv_d     = 1'b0;
    err_d    = 1'b0;
    rdata_d  = 32'h0;
    req_d    = 1'b0;
    mwe_d    = 1'b0;
    maddr_d  = 32'h0;
    mwdata_d = 32'h0;
    mbe_d    = 4'h0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_valid) begin
          off_d   = addr[1:0];
          mask_d  = mask;
          wdata_d = wr_data;
          we_d    = mem_wr;
          ready_d = 1'b0;
          if (illegal) begin
            state_d = RESP;
            rv_d    = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d  = ACC0;
            cnt_d    = '0;
            req_d    = 1'b1;
            mwe_d    = mem_wr;
            maddr_d  = {addr[31:2], 2'b00};
            mbe_d    = be_wide[3:0];
            mwdata_d = wd_wide[31:0];
          end
        end
      end
      ACC0, ACC1: begin
        req_d    = 1'b1;
        mwe_d    = m_we;
        maddr_d  = m_addr;
        mbe_d    = m_be;
        mwdata_d = m_wdata;
        if (m_ack) begin
          if (state_q == ACC0 && split) begin
            state_d  = ACC1;
            lo_d     = m_rdata;
            cnt_d    = '0;
            maddr_d  = m_addr + 32'd4;
            mbe_d    = be_wide[7:4];
            mwdata_d = wd_wide[63:32];
          end else begin
            state_d = RESP;
            req_d   = 1'b0;
            rv_d    = 1'b1;
            if (!we_q)
              rdata_d = (state_q == ACC0) ? extend(m_rdata, 32'h0, off_q, mask_q)
                                          : extend(lo_q, m_rdata, off_q, mask_q);
          end
        end else if (cnt_q == CNT_W'(MEM_LAT_MAX - 1)) begin
          // Memory never answered: abandon the access and report an error
          state_d = RESP;
          req_d   = 1'b0;
          rv_d    = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (!req_d) begin
          mwe_d    = 1'b0;
          maddr_d  = 32'h0;
          mbe_d    = 4'h0;
          mwdata_d = 32'h0;
        end
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      off_q     <= 2'b00;
      mask_q    <= 3'b000;
      wdata_q   <= 32'h0;
      we_q      <= 1'b0;
      lo_q      <= 32'h0;
      cnt_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0;
      err       <= 1'b0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= 32'h0;
      m_wdata   <= 32'h0;
      m_be      <= 4'h0;
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      mask_q    <= mask_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      req_ready <= ready_d;
      rsp_valid <= rv_d;
      rsp_data  <= rdata_d;
      err       <= err_d;
      m_req     <= req_d;
      m_we      <= mwe_d;
      m_addr    <= maddr_d;
      m_wdata   <= mwdata_d;
      m_be      <= mbe_d;
    end
  end

  // Core is held whenever the unit is busy, or is being handed a request right now
  assign stall = ~req_ready | req_valid;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: aligned, sub-word, split, wrap, backpressure,
// timeout, illegal and mid-access reset cases with hand-computed expectations.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        mem_rd;
  logic        mem_wr;
  logic [2:0]  mask;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        err;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ack;
  logic [31:0] m_rdata;

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.MEM_LAT_MAX(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mask(mask), .addr(addr), .wr_data(wr_data),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle; returns in the cycle after acceptance
  task automatic issue(input logic rd, input logic wr, input logic [2:0] mk,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; mem_rd = rd; mem_wr = wr; mask = mk; addr = a; wr_data = wd;
    tick();
    req_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  task automatic ack(input logic [31:0] rd);
    m_ack = 1'b1; m_rdata = rd;
    tick();
    m_ack = 1'b0; m_rdata = 32'h0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; req_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    mask = 3'b000; addr = 32'h0; wr_data = 32'h0; m_ack = 1'b0; m_rdata = 32'h0;
    tick(); tick();
    check("rst_ready", 32'(req_ready), 32'h1);
    check("rst_mreq", 32'(m_req), 32'h0);
    check("rst_rsp", 32'(rsp_valid), 32'h0);
    check("rst_be", 32'(m_be), 32'h0);
    rst = 1'b0;
    tick();

    // m_ack while idle must be ignored
    m_ack = 1'b1; tick(); m_ack = 1'b0; tick();
    check("idle_ack_rsp", 32'(rsp_valid), 32'h0);
    check("idle_ack_ready", 32'(req_ready), 32'h1);

    // LW aligned, same-cycle ack
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
    check("lw_mreq", 32'(m_req), 32'h1);
    check("lw_maddr", m_addr, 32'h0000_0100);
    check("lw_be", 32'(m_be), 32'hF);
    check("lw_we", 32'(m_we), 32'h0);
    check("lw_stall", 32'(stall), 32'h1);
    ack(32'hDEAD_BEEF);
    check("lw_rsp", 32'(rsp_valid), 32'h1);
    check("lw_data", rsp_data, 32'hDEAD_BEEF);
    check("lw_err", 32'(err), 32'h0);
    check("lw_mreq_off", 32'(m_req), 32'h0);
    tick();
    check("lw_ready", 32'(req_ready), 32'h1);
    check("lw_rsp_pulse", 32'(rsp_valid), 32'h0);

    // LB / LBU at offset 3
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
    check("lb_be", 32'(m_be), 32'h8);
    ack(32'h8012_3456);
    check("lb_data", rsp_data, 32'hFFFF_FF80);
    tick();
    issue(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0);
    ack(32'h8012_3456);
    check("lbu_data", rsp_data, 32'h0000_0080);
    tick();

    // LH at offset 2 (no split)
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0);
    check("lh_be", 32'(m_be), 32'hC);
    ack(32'h7FFE_1234);
    check("lh_data", rsp_data, 32'h0000_7FFE);
    tick();

    // Split SW at offset 2
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'h1122_3344);
    check("sw0_maddr", m_addr, 32'h0000_0100);
    check("sw0_be", 32'(m_be), 32'hC);
    check("sw0_wdata", m_wdata, 32'h3344_0000);
    check("sw0_we", 32'(m_we), 32'h1);
    ack(32'h0);
    check("sw1_mreq", 32'(m_req), 32'h1);
    check("sw1_maddr", m_addr, 32'h0000_0104);
    check("sw1_be", 32'(m_be), 32'h3);
    check("sw1_wdata", m_wdata, 32'h0000_1122);
    check("sw1_rsp", 32'(rsp_valid), 32'h0);
    ack(32'h0);
    check("sw_rsp", 32'(rsp_valid), 32'h1);
    check("sw_data", rsp_data, 32'h0);
    check("sw_err", 32'(err), 32'h0);
    tick();

    // Split LH with address wrap
    issue(1'b1, 1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0);
    check("wrap0_maddr", m_addr, 32'hFFFF_FFFC);
    check("wrap0_be", 32'(m_be), 32'h8);
    ack(32'hAB00_0000);
    check("wrap1_maddr", m_addr, 32'h0000_0000);
    check("wrap1_be", 32'(m_be), 32'h1);
    ack(32'h0000_00CD);
    check("wrap_rsp", 32'(rsp_valid), 32'h1);
    check("wrap_data", rsp_data, 32'hFFFF_CDAB);
    tick();

    // SH with ack delayed 3 cycles: transaction held stable
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0206, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      check("bp_mreq", 32'(m_req), 32'h1);
      check("bp_maddr", m_addr, 32'h0000_0204);
      check("bp_be", 32'(m_be), 32'hC);
      check("bp_wdata", m_wdata, 32'hF00D_0000);
      check("bp_stall", 32'(stall), 32'h1);
      tick();
    end
    ack(32'h0);
    check("bp_rsp", 32'(rsp_valid), 32'h1);
    check("bp_err", 32'(err), 32'h0);
    tick();

    // Timeout: no ack, error response 16 cycles after ACC0 entry
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
    for (int i = 0; i < 16; i++) begin
      check("to_wait_rsp", 32'(rsp_valid), 32'h0);
      check("to_wait_mreq", 32'(m_req), 32'h1);
      tick();
    end
    check("to_rsp", 32'(rsp_valid), 32'h1);
    check("to_err", 32'(err), 32'h1);
    check("to_data", rsp_data, 32'h0);
    check("to_mreq", 32'(m_req), 32'h0);
    tick();
    check("to_ready", 32'(req_ready), 32'h1);

    // Illegal requests answer at T+1 with no memory traffic
    issue(1'b1, 1'b0, 3'b011, 32'h0000_0400, 32'h0);
    check("ill_mask_rsp", 32'(rsp_valid), 32'h1);
    check("ill_mask_err", 32'(err), 32'h1);
    check("ill_mask_mreq", 32'(m_req), 32'h0);
    tick();
    check("ill_mask_ready", 32'(req_ready), 32'h1);
    issue(1'b0, 1'b1, 3'b100, 32'h0000_0400, 32'h55);
    check("ill_su_err", 32'(err), 32'h1);
    check("ill_su_mreq", 32'(m_req), 32'h0);
    tick();
    issue(1'b1, 1'b1, 3'b010, 32'h0000_0400, 32'h0);
    check("ill_rw_err", 32'(err), 32'h1);
    tick();

    // Reset in ACC1 abandons the access
    issue(1'b1, 1'b0, 3'b001, 32'h0000_01FF, 32'h0);
    ack(32'h1100_0000);
    check("rst1_mreq", 32'(m_req), 32'h1);
    check("rst1_maddr", m_addr, 32'h0000_0200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst1_mreq_off", 32'(m_req), 32'h0);
    check("rst1_ready", 32'(req_ready), 32'h1);
    check("rst1_rsp", 32'(rsp_valid), 32'h0);
    tick();
    check("rst1_rsp_after", 32'(rsp_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
